// File: rtl/hms_time_counter.sv
// hms_time_counter: 24 h hours:minutes:seconds time-of-day core.
// A prescaler derives a 1 Hz tick from clk. A two-button set mode selects hours, then minutes.
// All outputs are registered; day_tick marks the 23:59:59 -> 00:00:00 rollover.
module hms_time_counter #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [5:0] hr,
    output logic [1:0] sel,
    output logic       sec_tick,
    output logic       day_tick
);

    localparam int unsigned   PW      = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);

    // State encoding doubles as the display blink select.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_H   = 2'b01,
        SET_M   = 2'b10,
        ILLEGAL = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hr_q, hr_d;
    logic          sec_tick_q, sec_tick_d;
    logic          day_tick_q, day_tick_d;
    logic          tick;

    // Next-state logic: prescaler, time fields, set-mode FSM and output pulses.
    always_comb begin
        state_d    = state_q;
        ps_d       = '0;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        tick       = 1'b0;

        case (state_q)
            RUN: begin
                tick = (ps_q == PS_LAST);
                ps_d = tick ? '0 : ps_q + 1'b1;
                if (tick) begin
                    sec_tick_d = 1'b1;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            if (hr_q == 6'd23) begin
                                hr_d       = '0;
                                day_tick_d = 1'b1;
                            end else begin
                                hr_d = hr_q + 6'd1;
                            end
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                // Entering SET_H wins over a coincident tick for sec only; min/hr carries stand.
                if (btn_mode) begin
                    state_d = SET_H;
                    sec_d   = '0;
                    ps_d    = '0;
                end
            end
            SET_H: begin
                if (btn_mode) begin
                    state_d = SET_M;
                end else if (btn_inc) begin
                    hr_d = (hr_q == 6'd23) ? '0 : hr_q + 6'd1;
                end
            end
            SET_M: begin
                if (btn_mode) begin
                    state_d = RUN;
                end else if (btn_inc) begin
                    min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared to 00:00:00 RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ps_q       <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ps_q       <= ps_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign sec      = sec_q;
    assign min      = min_q;
    assign hr       = hr_q;
    assign sel      = state_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter with CLK_HZ=4.
// The reference model keeps time as seconds-of-day and derives fields arithmetically.
module tb_hms_time_counter;

    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec, min, hr;
    logic [1:0] sel;
    logic       sec_tick, day_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=RUN 1=SET_H 2=SET_M, t = seconds since midnight,
    // cnt = clocks spent in RUN since the last tick or RUN entry.
    int m_mode, m_t, m_cnt;
    bit exp_st, exp_dt;

    hms_time_counter #(.CLK_HZ(HZ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .sel      (sel),
        .sec_tick (sec_tick),
        .day_tick (day_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [21:0] dut_vec();
        return {hr, min, sec, sel, sec_tick, day_tick};
    endfunction

    function automatic logic [21:0] model_vec();
        return {6'(m_t / 3600), 6'((m_t / 60) % 60), 6'(m_t % 60), 2'(m_mode), exp_st, exp_dt};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_cnt = 0; exp_st = 0; exp_dt = 0;
    endtask

    task automatic model_step(input bit bm, input bit bi);
        int h, mm;
        exp_st = 0;
        exp_dt = 0;
        case (m_mode)
            0: begin
                m_cnt++;
                if (m_cnt == HZ) begin
                    m_cnt  = 0;
                    m_t    = (m_t + 1) % 86400;
                    exp_st = 1;
                    if (m_t == 0) exp_dt = 1;
                end
                if (bm) begin
                    m_mode = 1;
                    m_t    = m_t - (m_t % 60);
                    m_cnt  = 0;
                end
            end
            1: begin
                if (bm) m_mode = 2;
                else if (bi) begin
                    h   = m_t / 3600;
                    m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
                end
            end
            default: begin
                if (bm) begin
                    m_mode = 0;
                    m_cnt  = 0;
                end else if (bi) begin
                    mm  = (m_t / 60) % 60;
                    m_t = m_t - mm * 60 + ((mm + 1) % 60) * 60;
                end
            end
        endcase
    endtask

    // Drive buttons for one clock, advance the model, sample 1 time unit after the edge.
    task automatic step(input bit bm, input bit bi);
        btn_mode = bm;
        btn_inc  = bi;
        @(posedge clk);
        model_step(bm, bi);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 22'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", dut_vec(), 22'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        int pulses = 0;
        int last = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL run_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (sec_tick === 1'b1) begin
                pulses++;
                checks++;
                if (i - last !== HZ) begin
                    errors++;
                    $display("FAIL run_tick_spacing i=%0d got=%0d exp=%0d", i, i - last, HZ);
                end
                last = i;
            end
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL run_tick_count got=%0d exp=4", pulses);
        end
        checks++;
        if (sec !== 6'd4) begin
            errors++;
            $display("FAIL run_sec got=%0d exp=4", sec);
        end
    endtask

    task automatic test_midnight();
        int days = 0;
        apply_reset();
        step(1, 0);
        repeat (23) step(0, 1);
        step(1, 0);
        repeat (59) step(0, 1);
        step(1, 0);
        for (int i = 0; i < 58 * HZ; i++) begin
            step(0, 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL preload_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
        checks++;
        if ({hr, min, sec} !== {6'd23, 6'd59, 6'd58}) begin
            errors++;
            $display("FAIL preload_time got=%0d:%0d:%0d exp=23:59:58", hr, min, sec);
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, 0);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL midnight_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
            if (day_tick === 1'b1) begin
                days++;
                checks++;
                if ({hr, min, sec} !== 18'd0) begin
                    errors++;
                    $display("FAIL day_tick_time got=%0d:%0d:%0d exp=0:0:0", hr, min, sec);
                end
            end
        end
        checks++;
        if (days !== 1) begin
            errors++;
            $display("FAIL day_tick_count got=%0d exp=1", days);
        end
    endtask

    task automatic test_set_wrap();
        apply_reset();
        step(1, 0);
        repeat (25) step(0, 1);
        step(1, 0);
        repeat (61) step(0, 1);
        step(1, 0);
        checks++;
        if ({hr, min, sel} !== {6'd1, 6'd1, 2'b00}) begin
            errors++;
            $display("FAIL set_wrap got=hr%0d min%0d sel%0d exp=hr1 min1 sel0", hr, min, sel);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL set_wrap_model got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_set_entry();
        apply_reset();
        repeat (30 * HZ) step(0, 0);
        checks++;
        if (sec !== 6'd30) begin
            errors++;
            $display("FAIL pre_entry_sec got=%0d exp=30", sec);
        end
        step(1, 0);
        for (int i = 0; i <= 20; i++) begin
            checks++;
            if (dut_vec() !== {18'd0, 2'b01, 2'b00}) begin
                errors++;
                $display("FAIL set_entry_hold i=%0d got=%h exp=%h", i, dut_vec(), {18'd0, 2'b01, 2'b00});
            end
            if (i < 20) step(0, 0);
        end
    endtask

    task automatic test_mode_inc_same_cycle();
        int wait_cyc = 0;
        step(1, 0);
        checks++;
        if (sel !== 2'b10) begin
            errors++;
            $display("FAIL enter_set_m got=%0d exp=2", sel);
        end
        step(1, 1);
        checks++;
        if ({sel, min} !== {2'b00, 6'd0}) begin
            errors++;
            $display("FAIL mode_inc_same got=sel%0d min%0d exp=sel0 min0", sel, min);
        end
        while (sec_tick !== 1'b1 && wait_cyc < 10) begin
            step(0, 0);
            wait_cyc++;
        end
        checks++;
        if (wait_cyc !== HZ) begin
            errors++;
            $display("FAIL first_tick_latency got=%0d exp=%0d", wait_cyc, HZ);
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL first_tick_model got=%h exp=%h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(1, 0);
        repeat (12) step(0, 1);
        step(1, 0);
        repeat (34) step(0, 1);
        step(1, 0);
        step(1, 0);
        checks++;
        if (dut_vec() !== {6'd12, 6'd34, 6'd0, 2'b01, 2'b00}) begin
            errors++;
            $display("FAIL pre_async got=%h exp=%h", dut_vec(), {6'd12, 6'd34, 6'd0, 2'b01, 2'b00});
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 22'd0) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", dut_vec(), 22'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit bm, bi;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            bm = ($urandom_range(0, 19) == 0);
            bi = ($urandom_range(0, 2) == 0);
            step(bm, bi);
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random_cycle i=%0d got=%h exp=%h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_midnight();
        test_set_wrap();
        test_set_entry();
        test_mode_inc_same_cycle();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
